// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier that retires DIGIT multiplier bits per cycle.
// Optional macro MULTIPLIER_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | waiting for valid_in; c_out holds the last result
// S_COMPUTING | accumulating one DIGIT-wide partial product per cycle
module shift_add_multiplier #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               valid_in,
  output logic [2*WIDTH-1:0] c_out,
  output logic               valid_out,
  output logic               busy_out
);

  localparam int N      = WIDTH / DIGIT;
  localparam int CW     = $clog2(N) + 1;
  localparam int PART_W = WIDTH + DIGIT;
  localparam int PROD_W = 2 * WIDTH;

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_COMPUTING = 1'b1;

  logic [0:0]        state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [PROD_W-1:0] product;
  logic [CW-1:0]     count;

  logic [PART_W-1:0] partial;
  logic [PROD_W-1:0] next_product;
  logic [WIDTH-1:0]  b_next;
  logic [31:0]       shift_amt;
  logic              finish;

  always_comb begin
    partial      = PART_W'(a_reg) * PART_W'(b_reg[DIGIT-1:0]);
    shift_amt    = 32'(count) * 32'(DIGIT);
    next_product = product + (PROD_W'(partial) << shift_amt);
    b_next       = b_reg >> DIGIT;
    finish       = (count == CW'(N - 1));
`ifdef MULTIPLIER_EARLY_EXIT_EN
    // Remaining multiplier digits are all zero, so the product is already final.
    finish       = finish | (b_next == '0);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      product   <= '0;
      count     <= '0;
      c_out     <= '0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
            product  <= '0;
            count    <= '0;
            busy_out <= 1'b1;
            state    <= S_COMPUTING;
          end
        end
        S_COMPUTING: begin
          b_reg   <= b_next;
          count   <= count + CW'(1);
          product <= next_product;
          if (finish) begin
            c_out     <= next_product;
            valid_out <= 1'b1;
            busy_out  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: 16/4, 256/8 and 8/8 instances against a plain-arithmetic model.
// Expected latency follows MULTIPLIER_EARLY_EXIT_EN when the bundle is built with it.
module tb_shift_add_multiplier;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic        s_rst, s_valid, s_vo, s_busy;
  logic [15:0] s_a, s_b;
  logic [31:0] s_c;

  logic         w_rst, w_valid, w_vo, w_busy;
  logic [255:0] w_a, w_b;
  logic [511:0] w_c;

  logic        u_rst, u_valid, u_vo, u_busy;
  logic [7:0]  u_a, u_b;
  logic [15:0] u_c;

  shift_add_multiplier #(.WIDTH(16), .DIGIT(4)) u_small (
    .clk_in(clk_in), .rst_in(s_rst), .a_in(s_a), .b_in(s_b), .valid_in(s_valid),
    .c_out(s_c), .valid_out(s_vo), .busy_out(s_busy));

  shift_add_multiplier #(.WIDTH(256), .DIGIT(8)) u_wide (
    .clk_in(clk_in), .rst_in(w_rst), .a_in(w_a), .b_in(w_b), .valid_in(w_valid),
    .c_out(w_c), .valid_out(w_vo), .busy_out(w_busy));

  shift_add_multiplier #(.WIDTH(8), .DIGIT(8)) u_unit (
    .clk_in(clk_in), .rst_in(u_rst), .a_in(u_a), .b_in(u_b), .valid_in(u_valid),
    .c_out(u_c), .valid_out(u_vo), .busy_out(u_busy));

  // Reference latency in cycles from accept edge to the valid_out edge.
  function automatic int exp_lat(input logic [255:0] b, input int w, input int d);
    int msb = -1;
    for (int i = 0; i < w; i++) if (b[i]) msb = i;
`ifdef MULTIPLIER_EARLY_EXIT_EN
    if (msb < 0) return 1;
    return (msb + d) / d;
`else
    return w / d;
`endif
  endfunction

  task automatic accept_small(input logic [15:0] a, input logic [15:0] b);
    s_a = a; s_b = b; s_valid = 1'b1;
    @(posedge clk_in); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_small(output int lat, output bit busy_ok);
    lat = -1; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_in); #1;
      if (s_vo === 1'b1) begin lat = n; break; end
      if (s_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic wait_wide(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_in); #1;
      if (w_vo === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    s_rst = 1'b1; w_rst = 1'b1; u_rst = 1'b1;
    s_valid = 1'b1; w_valid = 1'b1; u_valid = 1'b1;
    s_a = 16'h1234; s_b = 16'h5678; w_a = '1; w_b = '1; u_a = 8'h11; u_b = 8'h22;
    repeat (2) @(posedge clk_in); #1;
    s_rst = 1'b0; w_rst = 1'b0; u_rst = 1'b0;
    s_valid = 1'b0; w_valid = 1'b0; u_valid = 1'b0;
    checks++; if ({s_c, s_vo, s_busy} !== 34'h0) begin errors++; $display("FAIL reset_small: got c=%h v=%b b=%b expected all 0", s_c, s_vo, s_busy); end
    checks++; if ({w_c, w_vo, w_busy} !== 514'h0) begin errors++; $display("FAIL reset_wide: got c=%h v=%b b=%b expected all 0", w_c, w_vo, w_busy); end
    checks++; if ({u_c, u_vo, u_busy} !== 18'h0) begin errors++; $display("FAIL reset_unit: got c=%h v=%b b=%b expected all 0", u_c, u_vo, u_busy); end
    @(posedge clk_in); #1;
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_valid_ignored: got busy=%b expected 0", s_busy); end
  endtask

  task automatic test_basic;
    int lat; bit busy_ok;
    accept_small(16'hFFFF, 16'hFFFF);
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept: got %b expected 1", s_busy); end
    wait_small(lat, busy_ok);
    checks++; if (lat != exp_lat(256'hFFFF, 16, 4)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(256'hFFFF, 16, 4)); end
    checks++; if (s_c !== 32'hFFFE0001) begin errors++; $display("FAIL basic_c: got %h expected %h", s_c, 32'hFFFE0001); end
    checks++; if (!busy_ok || s_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy_ok=%b busy_at_done=%b expected 1/0", busy_ok, s_busy); end
    @(posedge clk_in); #1;
    checks++; if (s_vo !== 1'b0 || s_c !== 32'hFFFE0001) begin errors++; $display("FAIL basic_pulse_hold: got v=%b c=%h expected 0/fffe0001", s_vo, s_c); end
  endtask

  task automatic test_operand_hold;
    int got = 0; int lat = -1; logic [31:0] c1 = '0;
    accept_small(16'h0003, 16'h0005);
    s_a = 16'hFFFF; s_b = 16'hFFFF; s_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk_in); #1;
      s_valid = 1'b0;
      if (s_vo === 1'b1) begin
        if (got == 0) begin lat = n; c1 = s_c; end
        got++;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL hold_pulse_count: got %0d expected 1", got); end
    checks++; if (lat != exp_lat(256'h5, 16, 4)) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", lat, exp_lat(256'h5, 16, 4)); end
    checks++; if (c1 !== 32'h0000000F || s_c !== 32'h0000000F) begin errors++; $display("FAIL hold_c: got %h/%h expected 0000000f", c1, s_c); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b expected 0", s_busy); end
  endtask

  task automatic test_reset_mid;
    int got = 0; int lat; bit busy_ok;
    accept_small(16'h00FF, 16'h00FF);
    @(posedge clk_in); #1;
    checks++; if (s_vo !== 1'b0) begin errors++; $display("FAIL rstmid_early_pulse: got %b expected 0", s_vo); end
    s_rst = 1'b1; s_valid = 1'b1;
    @(posedge clk_in); #1;
    s_rst = 1'b0; s_valid = 1'b0;
    checks++; if ({s_c, s_vo, s_busy} !== 34'h0) begin errors++; $display("FAIL rstmid_outputs: got c=%h v=%b b=%b expected all 0", s_c, s_vo, s_busy); end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk_in); #1;
      if (s_vo === 1'b1 || s_busy === 1'b1) got++;
    end
    checks++; if (got != 0) begin errors++; $display("FAIL rstmid_no_result: got %0d active cycles expected 0", got); end
    accept_small(16'h00FF, 16'h00FF);
    wait_small(lat, busy_ok);
    checks++; if (s_c !== 32'h0000FE01 || lat != exp_lat(256'hFF, 16, 4)) begin errors++; $display("FAIL rstmid_fresh: got c=%h lat=%0d expected 0000fe01 lat=%0d", s_c, lat, exp_lat(256'hFF, 16, 4)); end
  endtask

  task automatic test_early_exit;
    int lat; bit busy_ok;
    accept_small(16'h1234, 16'h0002);
    wait_small(lat, busy_ok);
    checks++; if (s_c !== 32'h00002468 || lat != exp_lat(256'h2, 16, 4)) begin errors++; $display("FAIL early_b2: got c=%h lat=%0d expected 00002468 lat=%0d", s_c, lat, exp_lat(256'h2, 16, 4)); end
    accept_small(16'h1234, 16'h0000);
    wait_small(lat, busy_ok);
    checks++; if (s_c !== 32'h0 || lat != exp_lat(256'h0, 16, 4)) begin errors++; $display("FAIL early_b0: got c=%h lat=%0d expected 00000000 lat=%0d", s_c, lat, exp_lat(256'h0, 16, 4)); end
  endtask

  task automatic test_back_to_back;
    int l1, l2, p1 = -1, p2 = -1, npulse = 0;
    logic [31:0] c1 = '0, c2 = '0;
    bit hold_ok = 1'b1;
    l1 = exp_lat(256'd3, 16, 4);
    l2 = exp_lat(256'd9, 16, 4);
    s_a = 16'd2; s_b = 16'd3; s_valid = 1'b1;
    @(posedge clk_in); #1;
    s_a = 16'd7; s_b = 16'd9;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk_in); #1;
      if (n == l1 + 1) s_valid = 1'b0;
      if (s_vo === 1'b1) begin
        if (npulse == 0) begin p1 = n; c1 = s_c; end
        else if (npulse == 1) begin p2 = n; c2 = s_c; end
        npulse++;
      end else if (npulse == 1 && s_c !== 32'd6) hold_ok = 1'b0;
    end
    s_valid = 1'b0;
    checks++; if (npulse != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", npulse); end
    checks++; if (p1 != l1 || c1 !== 32'd6) begin errors++; $display("FAIL b2b_first: got edge %0d c=%0d expected edge %0d c=6", p1, c1, l1); end
    checks++; if (p2 != l1 + 1 + l2 || c2 !== 32'd63) begin errors++; $display("FAIL b2b_second: got edge %0d c=%0d expected edge %0d c=63", p2, c2, l1 + 1 + l2); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL b2b_hold: got c_out change between results expected 6 held"); end
  endtask

  task automatic test_random_small;
    int lat; bit busy_ok;
    logic [15:0] a, b;
    logic [31:0] e;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 16);
      e = 32'(a) * 32'(b);
      accept_small(a, b);
      wait_small(lat, busy_ok);
      checks++;
      if (s_c !== e || lat != exp_lat(256'(b), 16, 4) || !busy_ok) begin
        errors++;
        $display("FAIL rand_small[%0d]: got c=%h lat=%0d busy_ok=%b expected c=%h lat=%0d busy_ok=1", i, s_c, lat, busy_ok, e, exp_lat(256'(b), 16, 4));
      end
    end
  endtask

  task automatic test_single_digit;
    logic [7:0] a, b;
    logic [15:0] e;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = (i == 0) ? 8'hFF : 8'($urandom);
      b = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom);
      e = 16'(a) * 16'(b);
      u_a = a; u_b = b; u_valid = 1'b1;
      @(posedge clk_in); #1;
      u_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk_in); #1;
        if (u_vo === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (u_c !== e || lat != 1 || u_busy !== 1'b0) begin
        errors++;
        $display("FAIL unit[%0d]: got c=%h lat=%0d busy=%b expected c=%h lat=1 busy=0", i, u_c, lat, u_busy, e);
      end
    end
  endtask

  task automatic test_full_width;
    logic [255:0] a, b;
    logic [511:0] e, ones_sq;
    int lat;
    ones_sq = '0;
    ones_sq[0] = 1'b1;
    ones_sq = ones_sq - (512'd1 << 257);
    for (int i = 0; i < 201; i++) begin
      if (i == 0) begin
        a = '1; b = '1;
      end else begin
        for (int j = 0; j < 8; j++) begin
          a[j*32 +: 32] = $urandom;
          b[j*32 +: 32] = $urandom;
        end
        b = b >> $urandom_range(0, 256);
      end
      e = (i == 0) ? ones_sq : 512'(a) * 512'(b);
      w_a = a; w_b = b; w_valid = 1'b1;
      @(posedge clk_in); #1;
      w_valid = 1'b0;
      wait_wide(lat);
      checks++;
      if (w_c !== e || lat != exp_lat(b, 256, 8) || w_busy !== 1'b0) begin
        errors++;
        $display("FAIL wide[%0d]: got lat=%0d busy=%b expected lat=%0d, c got %h", i, lat, w_busy, exp_lat(b, 256, 8), w_c);
        $display("FAIL wide[%0d]: c expected %h", i, e);
      end
    end
  endtask

  initial begin
    s_rst = 1'b1; w_rst = 1'b1; u_rst = 1'b1;
    s_valid = 1'b0; w_valid = 1'b0; u_valid = 1'b0;
    s_a = '0; s_b = '0; w_a = '0; w_b = '0; u_a = '0; u_b = '0;
    test_reset;
    test_basic;
    test_operand_hold;
    test_reset_mid;
    test_early_exit;
    test_back_to_back;
    test_random_small;
    test_single_digit;
    test_full_width;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Multi-cycle unsigned multiplier, parametrised in operand width and in bits retired per cycle (DIGIT). It replaces the one-bit-per-cycle key-generation multiplier. Operands are latched on acceptance, so callers need not hold `a_in`/`b_in` stable during the computation. It also fixes the result-valid protocol to a clean one-cycle pulse, and can optionally terminate early when the remaining multiplier bits are zero. It sits in the key-generation path and feeds the modular-reduction stage.

## Interface
- `WIDTH`, 256: operand width in bits. Product width is 2*WIDTH.
- `DIGIT`, 4: multiplier bits consumed per compute cycle.
  - Must divide WIDTH, with 1 ≤ DIGIT ≤ WIDTH.
  - N = WIDTH/DIGIT.
- `clk_in`  input  1  single clock; all logic on its rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `a_in`  input  WIDTH  multiplicand; sampled only on the accept edge.
- `b_in`  input  WIDTH  multiplier; sampled only on the accept edge.
- `valid_in`  input  1  request; accepted only when state is IDLE.
- `c_out`  output  2*WIDTH  a*b, unsigned; held until the next result is written.
- `valid_out`  output  1  one-cycle pulse marking a new `c_out`.
- `busy_out`  output  1  high from the accept edge through the last compute cycle.

## Operation
- States: IDLE, COMPUTING.
- Registers: `a_reg` (WIDTH), `b_reg` (WIDTH), `product` (2*WIDTH), `count` ($clog2(N)+1 bits).
- **IDLE**, with `valid_in` high:
  - `a_reg<=a_in`, `b_reg<=b_in`, `product<=0`, `count<=0`, `busy_out<=1`.
  - Next state COMPUTING.
  - With `valid_in` low: no change.
- **COMPUTING**, each cycle:
  - partial = `a_reg` * `b_reg[DIGIT-1:0]` (WIDTH+DIGIT bits).
  - next_product = `product` + (partial << (DIGIT*`count`)), computed in 2*WIDTH bits; no overflow is possible.
  - `b_reg <= b_reg >> DIGIT`; `count<=count+1`; `product<=next_product`.
- Finish condition: `count==N-1`, or the early-exit condition (see Configuration).
- On the finish cycle:
  - `c_out<=next_product`, `valid_out<=1`, `busy_out<=0`.
  - Next state IDLE.
- `valid_out` is cleared on every edge that does not finish.
- `valid_in` during COMPUTING is ignored, not queued. Callers gate on `busy_out==0`.
- `a_in`/`b_in` changes after the accept edge have no effect.
- Zero operands need no special case. A result of 0 still pulses `valid_out`.

## Timing
- Accept at edge k. `busy_out` is high after edge k.
- Full-latency finish at edge k+N: `valid_out` high for cycle k+N..k+N+1, `busy_out` low from k+N.
- Back-to-back: the earliest next accept is edge k+N+1, during the `valid_out` pulse cycle. This sustains one result per N+1 cycles.
- Reset asserted at any edge, including mid-computation:
  - State IDLE; `product`, `count`, `a_reg`, `b_reg` = 0.
  - `c_out=0`, `valid_out=0`, `busy_out=0`.
  - Any in-flight result is discarded and no `valid_out` pulse is produced for it.
- `valid_in` high in the same cycle as reset is ignored.
- DIGIT=WIDTH (N=1): finish at edge k+1.

## Configuration
- Macro `MULTIPLIER_EARLY_EXIT_EN`.
- Defined: the finish condition also fires when `(b_reg >> DIGIT)==0` in the current COMPUTING cycle.
  - Latency = max(1, ceil(msb_index(b)+1 / DIGIT)) cycles.
  - b=0 finishes at edge k+1.
  - `c_out` is identical to the full-latency result.
- Undefined: latency is always exactly N cycles, independent of operand values. This is the constant-time mode for key material.

## Test plan
All scenarios use bench parameters WIDTH=16, DIGIT=4 (N=4) unless stated otherwise.
- **Basic:** a=0xFFFF, b=0xFFFF, accept at edge 0.
  - `c_out`=0xFFFE0001 with `valid_out` pulsed exactly one cycle at edge 4.
  - `busy_out` high for edges 1–3.
- **Operand hold:** accept a=0x0003, b=0x0005, then drive a=0xFFFF, b=0xFFFF during compute.
  - `c_out`=0x0000000F.
  - A `valid_in` asserted mid-compute produces no second result.
- **Early exit:** a=0x1234, b=0x0002.
  - Macro defined: `valid_out` at edge 1 with `c_out`=0x00002468.
  - Macro undefined: same `c_out`, at edge 4.
  - b=0 gives `c_out`=0 (edge 1 defined, edge 4 undefined).
- **Reset mid-operation:** accept a=0x00FF, b=0x00FF, assert `rst_in` at edge 2.
  - All outputs 0, no `valid_out` pulse.
  - A fresh request after reset yields 0x0000FE01.
- **Back-to-back:** request 2×3 accepted at edge 0, then 7×9 accepted at edge 5 (`valid_in` held high).
  - `c_out`=6 at edge 4, `c_out`=63 at edge 9.
  - `c_out` holds 6 between the two results.
- **Full-width:** WIDTH=256, DIGIT=8, a=b=2^256−1.
  - `c_out`=2^512−2^257+1 after 32 cycles.
  - Plus 200 random operand pairs checked against a reference model.
